// File: rtl/axi4_mem_model.sv
// Simulation AXI4 slave memory: INCR bursts, independent read/write engines, byte-addressable mem[].
// Memory is zero-filled at time 0; benches preload it over AXI or hierarchically.
module axi4_mem_model #(
    parameter int ADDR_BITS = 21,
    parameter int DATA_W    = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_axi_awvalid,
    output logic                m_axi_awready,
    input  logic [63:0]         m_axi_awaddr,
    input  logic [7:0]          m_axi_awlen,
    input  logic [2:0]          m_axi_awsize,
    input  logic                m_axi_wvalid,
    output logic                m_axi_wready,
    input  logic [DATA_W-1:0]   m_axi_wdata,
    input  logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_wlast,
    output logic                m_axi_bvalid,
    input  logic                m_axi_bready,
    input  logic                m_axi_arvalid,
    output logic                m_axi_arready,
    input  logic [63:0]         m_axi_araddr,
    input  logic [7:0]          m_axi_arlen,
    input  logic [2:0]          m_axi_arsize,
    output logic                m_axi_rvalid,
    input  logic                m_axi_rready,
    output logic [DATA_W-1:0]   m_axi_rdata,
    output logic                m_axi_rlast
);
    localparam int LANES     = DATA_W / 8;
    localparam int SZ_MAX    = $clog2(LANES);
    localparam int MEM_BYTES = 2 ** ADDR_BITS;

    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    logic [7:0] mem [0:MEM_BYTES-1];

    wstate_t    w_state_q;
    addr_t      waddr_q;
    logic [7:0] wlen_q, wcnt_q;
    logic [2:0] wsz_q;
    logic       awready_q, wready_q, bvalid_q;

    rstate_t    r_state_q;
    addr_t      raddr_q;
    logic [7:0] rlen_q, rcnt_q;
    logic [2:0] rsz_q;
    logic       arready_q, rvalid_q, rlast_q;

    logic       unused_s;

    function automatic logic [2:0] clamp_size(input logic [2:0] sz);
        return (sz > 3'(SZ_MAX)) ? 3'(SZ_MAX) : sz;
    endfunction

    // Zero-fill at time 0.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    end

    // Write engine: address latch, data beats counted against awlen, response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            wsz_q     <= 3'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && m_axi_awvalid) begin
                        waddr_q   <= m_axi_awaddr[ADDR_BITS-1:0];
                        wlen_q    <= m_axi_awlen;
                        wsz_q     <= clamp_size(m_axi_awsize);
                        wcnt_q    <= 8'd0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (m_axi_wvalid) begin
                        if (m_axi_wlast != (wcnt_q == wlen_q)) $display("WARN: wlast mismatch");
                        waddr_q <= waddr_q + (addr_t'(1) << wsz_q);
                        wcnt_q  <= wcnt_q + 8'd1;
                        if (wcnt_q == wlen_q) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (m_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane writes; lane address wraps modulo the memory size.
    always_ff @(posedge clk) begin
        if (!rst && (w_state_q == W_DATA) && m_axi_wvalid) begin
            for (int i = 0; i < LANES; i++) begin
                if (m_axi_wstrb[i]) mem[waddr_q + addr_t'(i)] <= m_axi_wdata[8*i +: 8];
            end
        end
    end

    // Read engine: address latch, one beat per rready, rlast tracked ahead of the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rsz_q     <= 3'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && m_axi_arvalid) begin
                        raddr_q   <= m_axi_araddr[ADDR_BITS-1:0];
                        rlen_q    <= m_axi_arlen;
                        rsz_q     <= clamp_size(m_axi_arsize);
                        rcnt_q    <= 8'd0;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (m_axi_arlen == 8'd0);
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (m_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_q + (addr_t'(1) << rsz_q);
                            rcnt_q  <= rcnt_q + 8'd1;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Read data follows the current beat address, so same-edge writes show up a cycle later.
    always_comb begin
        m_axi_rdata = '0;
        if (rvalid_q) begin
            for (int i = 0; i < LANES; i++) m_axi_rdata[8*i +: 8] = mem[raddr_q + addr_t'(i)];
        end else begin
            m_axi_rdata = '0;
        end
    end

    assign m_axi_awready = awready_q;
    assign m_axi_wready  = wready_q;
    assign m_axi_bvalid  = bvalid_q;
    assign m_axi_arready = arready_q;
    assign m_axi_rvalid  = rvalid_q;
    assign m_axi_rlast   = rlast_q;
    assign unused_s      = ^{m_axi_awaddr[63:ADDR_BITS], m_axi_araddr[63:ADDR_BITS]};

endmodule

// File: tb/tb_axi4_mem_model.sv
// Directed plus randomized bench for axi4_mem_model against a byte-level reference memory.
module tb_axi4_mem_model;
    localparam int     AB    = 21;
    localparam int     DW    = 256;
    localparam int     NL    = DW / 8;
    localparam longint MEMSZ = longint'(1) << AB;

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [63:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [DW-1:0] wdata, rdata;
    logic [NL-1:0] wstrb;

    axi4_mem_model #(.ADDR_BITS(AB), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rlast(rlast)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    ref_mem [longint];
    logic [DW-1:0] beat_data [$];
    logic [NL-1:0] beat_strb [$];

    function automatic longint wrap(input logic [63:0] a);
        return longint'(a & 64'(MEMSZ - 1));
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        longint k = wrap(a);
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    function automatic longint stride_of(input int size);
        return longint'(1) << ((size > 5) ? 5 : size);
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return awready;
            1:       return wready;
            2:       return bvalid;
            3:       return arready;
            4:       return rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_for(input int w, input string tag);
        int n = 0;
        while (sig(w) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL %s: timeout observed 0 expected 1", tag);
        end
    endtask

    // Entered and left at a negedge; beats come from beat_data/beat_strb.
    task automatic axi_write(input logic [63:0] addr, input int len, input int size,
                             input bit bstall, input bit bad_last);
        longint st = stride_of(size);
        awvalid = 1'b1; awaddr = addr; awlen = len[7:0]; awsize = size[2:0];
        wait_for(0, "awready");
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b1; wdata = beat_data[b]; wstrb = beat_strb[b];
            wlast  = bad_last ? (b == 0) : (b == len);
            wait_for(1, "wready");
            for (int i = 0; i < NL; i++)
                if (beat_strb[b][i]) ref_mem[wrap(addr + 64'(b) * 64'(st) + 64'(i))] = beat_data[b][8*i +: 8];
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_last_beat", DW'(bvalid), DW'(1));
        if (bstall) begin
            repeat (5) begin
                @(negedge clk);
                check("bvalid_held", DW'(bvalid), DW'(1));
                check("awready_low_in_resp", DW'(awready), DW'(0));
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_cleared", DW'(bvalid), DW'(0));
        check("awready_after_b", DW'(awready), DW'(1));
    endtask

    task automatic axi_read(input logic [63:0] addr, input int len, input int size, input int stall_beat);
        longint st = stride_of(size);
        logic [DW-1:0] expv;
        arvalid = 1'b1; araddr = addr; arlen = len[7:0]; arsize = size[2:0];
        wait_for(3, "arready");
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wait_for(4, "rvalid");
            for (int i = 0; i < NL; i++) expv[8*i +: 8] = ref_rd(addr + 64'(b) * 64'(st) + 64'(i));
            check("rdata", rdata, expv);
            check("rlast", DW'(rlast), DW'(b == len));
            if (b == stall_beat) begin
                repeat (5) begin
                    @(negedge clk);
                    check("rvalid_stall", DW'(rvalid), DW'(1));
                    check("rdata_stall", rdata, expv);
                    check("rlast_stall", DW'(rlast), DW'(b == len));
                end
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check("rvalid_done", DW'(rvalid), DW'(0));
    endtask

    task automatic fill_beats(input int n, input bit full_strb);
        beat_data.delete(); beat_strb.delete();
        for (int b = 0; b < n; b++) begin
            beat_data.push_back(rand_beat());
            beat_strb.push_back(full_strb ? {NL{1'b1}} : NL'($urandom));
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; awaddr = 64'd0; araddr = 64'd0;
        awlen = 8'd0; arlen = 8'd0; awsize = 3'd0; arsize = 3'd0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", DW'(awready), DW'(0));
        check("rst_arready", DW'(arready), DW'(0));
        check("rst_outputs", DW'({wready, bvalid, rvalid, rlast}), DW'(0));
        check("rst_rdata", rdata, '0);
        rst = 1'b0;
        @(negedge clk);
        check("awready_after_rst", DW'(awready), DW'(1));
        check("arready_after_rst", DW'(arready), DW'(1));

        // Single beat, bytes 0x00..0x1F at 0x100.
        for (int i = 0; i < NL; i++) d[8*i +: 8] = 8'(i);
        beat_data.delete(); beat_strb.delete();
        beat_data.push_back(d); beat_strb.push_back({NL{1'b1}});
        axi_write(64'h100, 0, 5, 1'b0, 1'b0);
        check("mem_0x11f", DW'(dut.mem[21'h11F]), DW'(8'h1F));
        axi_read(64'h100, 0, 5, -1);

        // Partial strobe over a 0x11 preload.
        beat_data.delete(); beat_strb.delete();
        beat_data.push_back({NL{8'h11}}); beat_strb.push_back({NL{1'b1}});
        axi_write(64'h400, 0, 5, 1'b0, 1'b0);
        beat_data.delete(); beat_strb.delete();
        beat_data.push_back({NL{8'hFF}}); beat_strb.push_back(NL'(1));
        axi_write(64'h400, 0, 5, 1'b0, 1'b0);
        check("strb_byte0", DW'(dut.mem[21'h400]), DW'(8'hFF));
        check("strb_byte1", DW'(dut.mem[21'h401]), DW'(8'h11));
        check("strb_byte31", DW'(dut.mem[21'h41F]), DW'(8'h11));
        axi_read(64'h400, 0, 5, -1);

        // Four-beat burst with B and R backpressure.
        fill_beats(4, 1'b1);
        axi_write(64'h2000, 3, 5, 1'b1, 1'b0);
        axi_read(64'h2000, 3, 5, 1);

        // Wrap past the top of memory.
        fill_beats(1, 1'b1);
        axi_write(64'h1F_FFF0, 0, 5, 1'b0, 1'b0);
        check("wrap_mem0", DW'(dut.mem[21'h0]), DW'(beat_data[0][8*16 +: 8]));
        axi_read(64'h0, 0, 5, -1);
        axi_read(64'h1F_FFF0, 0, 5, -1);

        // Early wlast: burst still ends on the beat count.
        fill_beats(2, 1'b1);
        axi_write(64'h5000, 1, 5, 1'b0, 1'b1);
        axi_read(64'h5000, 1, 5, -1);

        // Reset after 2 of 4 beats; further W traffic must be dropped.
        fill_beats(4, 1'b1);
        awvalid = 1'b1; awaddr = 64'h3000; awlen = 8'd3; awsize = 3'd5;
        wait_for(0, "awready_rstburst");
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wvalid = 1'b1; wdata = beat_data[b]; wstrb = {NL{1'b1}}; wlast = 1'b0;
            for (int i = 0; i < NL; i++) ref_mem[wrap(64'h3000 + 64'(32 * b + i))] = beat_data[b][8*i +: 8];
            @(negedge clk);
        end
        wdata = beat_data[2];
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", DW'({awready, wready, bvalid, arready, rvalid, rlast}), DW'(0));
        rst = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        check("midrst_awready", DW'(awready), DW'(1));
        axi_read(64'h3000, 3, 5, -1);

        // Randomized bursts with random sizes, strobes and upper address bits.
        for (int t = 0; t < 12; t++) begin
            logic [63:0] a;
            int len, sz;
            a   = {32'($urandom_range(0, 3)), 32'($urandom_range(0, int'(MEMSZ) - 1))};
            len = $urandom_range(0, 7);
            sz  = $urandom_range(0, 7);
            fill_beats(len + 1, 1'b0);
            axi_write(a, len, sz, 1'b0, 1'b0);
            axi_read(a, $urandom_range(0, 7), $urandom_range(0, 7), (t % 3 == 0) ? 0 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
